// File: rtl/sevenseg_capture.sv
// sevenseg_capture: decode a multiplexed active-low seven-segment bus back into hex frames
//   clk, rst           : clock, asynchronous active-high reset
//   an, seg            : digit enables and segment lines (active-low, seg[6]=a .. seg[0]=g)
//   dig_strobe/idx/code/blank/err : one-cycle report of each accepted digit
//   frame_valid/value/blank/err   : one-cycle pulse plus held data for each complete frame
module sevenseg_capture #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIGITS-1:0]     an,
  input  logic [6:0]            seg,
  output logic                  dig_strobe,
  output logic [2:0]            dig_idx,
  output logic [3:0]            dig_code,
  output logic                  dig_blank,
  output logic                  dig_err,
  output logic                  frame_valid,
  output logic [4*DIGITS-1:0]   frame_value,
  output logic [DIGITS-1:0]     frame_blank,
  output logic                  frame_err
);
  localparam logic [7:0] SC = 8'(STABLE_CYCLES);
  logic [DIGITS-1:0]   s_an_q;
  logic [6:0]          s_seg_q;
  logic [7:0]          cnt_q, cnt_d;
  logic [DIGITS-1:0]   lo, mask_q, mask_d, w_blank_q, w_blank_d, w_err_q, w_err_d, n_err;
  logic [4*DIGITS-1:0] w_val_q, w_val_d;
  logic [6:0]          pat;
  logic                live, same, acc, done, blank, err;
  logic [2:0]          idx;
  logic [3:0]          code;
  // The incoming sample is compared against the previous one (held in s_an/s_seg),
  // so the accepting edge is the one that registers the final sample of the run.
  always_comb begin
    lo    = ~an;
    live  = $countones(lo) == 1;
    same  = an == s_an_q && seg == s_seg_q;
    cnt_d = !live ? 8'd0 : !same ? 8'd1 : cnt_q == SC ? cnt_q : cnt_q + 8'd1;
    acc   = live && same && cnt_q == SC - 8'd1;
    idx   = '0;
    for (int i = 0; i < DIGITS; i++) if (lo[i]) idx = 3'(i);
  end
  always_comb begin
    pat   = ~seg;
    code  = '0;
    blank = 1'b0;
    err   = 1'b0;
    case (pat)
      7'h7E: code = 4'h0;
      7'h30: code = 4'h1;
      7'h6D: code = 4'h2;
      7'h79: code = 4'h3;
      7'h33: code = 4'h4;
      7'h5B: code = 4'h5;
      7'h5F: code = 4'h6;
      7'h70: code = 4'h7;
      7'h7F: code = 4'h8;
      7'h73: code = 4'h9;
      7'h77: code = 4'hA;
      7'h1F: code = 4'hB;
      7'h4E: code = 4'hC;
      7'h3D: code = 4'hD;
      7'h4F: code = 4'hE;
      7'h47: code = 4'hF;
      7'h00: blank = 1'b1;
      default: err = 1'b1;
    endcase
  end
  // Working frame: the live digit's slot is overwritten on every acceptance.
  always_comb begin
    w_val_d   = w_val_q;
    w_blank_d = w_blank_q;
    n_err     = w_err_q;
    for (int i = 0; i < DIGITS; i++)
      if (acc && lo[i]) begin
        w_val_d[4*i +: 4] = code;
        w_blank_d[i]      = blank;
        n_err[i]          = err;
      end
    done    = acc && &(mask_q | lo);
    mask_d  = done ? '0 : acc ? (mask_q | lo) : mask_q;
    w_err_d = done ? '0 : n_err;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_an_q      <= '1;
      s_seg_q     <= 7'h7F;
      cnt_q       <= '0;
      mask_q      <= '0;
      w_val_q     <= '0;
      w_blank_q   <= '0;
      w_err_q     <= '0;
      dig_strobe  <= 1'b0;
      dig_idx     <= '0;
      dig_code    <= '0;
      dig_blank   <= 1'b0;
      dig_err     <= 1'b0;
      frame_valid <= 1'b0;
      frame_value <= '0;
      frame_blank <= '0;
      frame_err   <= 1'b0;
    end else begin
      s_an_q      <= an;
      s_seg_q     <= seg;
      cnt_q       <= cnt_d;
      mask_q      <= mask_d;
      w_val_q     <= w_val_d;
      w_blank_q   <= w_blank_d;
      w_err_q     <= w_err_d;
      dig_strobe  <= acc;
      frame_valid <= done;
      if (acc) begin
        dig_idx   <= idx;
        dig_code  <= code;
        dig_blank <= blank;
        dig_err   <= err;
      end
      if (done) begin
        frame_value <= w_val_d;
        frame_blank <= w_blank_d;
        frame_err   <= |n_err;
      end
    end
  end
endmodule

// File: tb/tb_sevenseg_capture.sv
// tb_sevenseg_capture: directed self-checking bench for sevenseg_capture
module tb_sevenseg_capture;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dig_strobe, dig_blank, dig_err, frame_valid, frame_err;
  logic [2:0]  dig_idx;
  logic [3:0]  dig_code, frame_blank;
  logic [15:0] frame_value;
  logic [0:0]  an1;
  logic [6:0]  seg1;
  logic        d1_strobe, d1_blank, d1_err, f1_valid, f1_err;
  logic [2:0]  d1_idx;
  logic [3:0]  d1_code, f1_value;
  logic [0:0]  f1_blank;
  int errors = 0, checks = 0;
  int nstr, nfr, str_at, str_cyc, fr_cyc, cyc = 0;
  logic [2:0]  l_idx;
  logic [3:0]  l_code;
  logic        l_blank, l_err;
  logic [6:0]  tbl [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                            7'h7F, 7'h73, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
  always #5 clk = ~clk;
  sevenseg_capture dut (
    .clk(clk), .rst(rst), .an(an), .seg(seg),
    .dig_strobe(dig_strobe), .dig_idx(dig_idx), .dig_code(dig_code), .dig_blank(dig_blank),
    .dig_err(dig_err), .frame_valid(frame_valid), .frame_value(frame_value),
    .frame_blank(frame_blank), .frame_err(frame_err));
  sevenseg_capture #(.DIGITS(1), .STABLE_CYCLES(2)) dut1 (
    .clk(clk), .rst(rst), .an(an1), .seg(seg1),
    .dig_strobe(d1_strobe), .dig_idx(d1_idx), .dig_code(d1_code), .dig_blank(d1_blank),
    .dig_err(d1_err), .frame_valid(f1_valid), .frame_value(f1_value),
    .frame_blank(f1_blank), .frame_err(f1_err));
  task automatic clr();
    nstr = 0; nfr = 0; str_at = -1; str_cyc = -1; fr_cyc = -2;
  endtask
  task automatic run(input logic [3:0] a, input logic [6:0] p, input int n);
    for (int k = 0; k < n; k++) begin
      an = a; seg = ~p;
      @(posedge clk); #1;
      cyc++;
      if (dig_strobe) begin
        nstr++; str_at = k; str_cyc = cyc;
        l_idx = dig_idx; l_code = dig_code; l_blank = dig_blank; l_err = dig_err;
      end
      if (frame_valid) begin nfr++; fr_cyc = cyc; end
    end
  endtask
  task automatic scan(input int i, input logic [6:0] p);
    run(~(4'b1 << i), p, 8);
    run(4'hF, 7'h00, 1);
  endtask
  task automatic test_reset();
    rst = 1'b1; an = 4'hF; seg = 7'h7F; an1 = 1'b1; seg1 = 7'h7F;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({dig_strobe, dig_idx, dig_code, dig_blank, dig_err} !== 10'd0) begin errors++; $display("FAIL reset_dig got=%h want=0", {dig_strobe, dig_idx, dig_code, dig_blank, dig_err}); end
    checks++; if ({frame_valid, frame_value, frame_blank, frame_err} !== 22'd0) begin errors++; $display("FAIL reset_frame got=%h want=0", {frame_valid, frame_value, frame_blank, frame_err}); end
    rst = 1'b0;
  endtask
  task automatic test_latency();
    clr();
    run(4'b1110, tbl[1], 6);
    checks++; if (nstr !== 1) begin errors++; $display("FAIL lat_count got=%0d want=1", nstr); end
    checks++; if (str_at !== 3) begin errors++; $display("FAIL lat_cycle got=%0d want=3", str_at); end
    checks++; if ({l_idx, l_code, l_blank, l_err} !== {3'd0, 4'd1, 1'b0, 1'b0}) begin errors++; $display("FAIL lat_data got=%h want=%h", {l_idx, l_code, l_blank, l_err}, {3'd0, 4'd1, 2'b00}); end
    checks++; if (nfr !== 0) begin errors++; $display("FAIL lat_noframe got=%0d want=0", nfr); end
    run(4'hF, 7'h00, 2);
  endtask
  task automatic test_full_frame();
    clr();
    scan(0, tbl[2]); scan(1, tbl[10]); scan(2, tbl[13]); scan(3, tbl[15]);
    checks++; if (nstr !== 4) begin errors++; $display("FAIL frame_strobes got=%0d want=4", nstr); end
    checks++; if (nfr !== 1) begin errors++; $display("FAIL frame_count got=%0d want=1", nfr); end
    checks++; if (fr_cyc !== str_cyc) begin errors++; $display("FAIL frame_align got=%0d want=%0d", fr_cyc, str_cyc); end
    checks++; if (frame_value !== 16'hFDA2) begin errors++; $display("FAIL frame_value got=%h want=fda2", frame_value); end
    checks++; if ({frame_blank, frame_err} !== 5'd0) begin errors++; $display("FAIL frame_flags got=%b want=00000", {frame_blank, frame_err}); end
  endtask
  task automatic test_glitch();
    clr();
    run(4'b1101, 7'h79, 3);
    run(4'b1101, 7'h33, 4);
    run(4'hF, 7'h00, 1);
    checks++; if (nstr !== 1) begin errors++; $display("FAIL glitch_count got=%0d want=1", nstr); end
    checks++; if ({l_idx, l_code} !== {3'd1, 4'd4}) begin errors++; $display("FAIL glitch_data got=%h want=%h", {l_idx, l_code}, {3'd1, 4'd4}); end
  endtask
  task automatic test_blank_invalid();
    clr();
    scan(0, tbl[3]); scan(1, tbl[7]);
    scan(2, 7'h01);
    checks++; if ({l_idx, l_code, l_blank, l_err} !== {3'd2, 4'd0, 1'b0, 1'b1}) begin errors++; $display("FAIL invalid_dig got=%h want=%h", {l_idx, l_code, l_blank, l_err}, {3'd2, 4'd0, 2'b01}); end
    scan(3, 7'h00);
    checks++; if ({l_idx, l_code, l_blank, l_err} !== {3'd3, 4'd0, 1'b1, 1'b0}) begin errors++; $display("FAIL blank_dig got=%h want=%h", {l_idx, l_code, l_blank, l_err}, {3'd3, 4'd0, 2'b10}); end
    checks++; if (nfr !== 1) begin errors++; $display("FAIL bi_count got=%0d want=1", nfr); end
    checks++; if ({frame_value, frame_blank, frame_err} !== {16'h0073, 4'b1000, 1'b1}) begin errors++; $display("FAIL bi_frame got=%h want=%h", {frame_value, frame_blank, frame_err}, {16'h0073, 4'b1000, 1'b1}); end
    clr();
    run(4'b1100, tbl[0], 10);
    run(4'hF, 7'h00, 1);
    checks++; if (nstr !== 0) begin errors++; $display("FAIL multilow got=%0d want=0", nstr); end
  endtask
  task automatic test_overwrite();
    clr();
    scan(0, tbl[5]); scan(0, tbl[6]);
    scan(1, tbl[1]); scan(2, tbl[2]); scan(3, tbl[3]);
    checks++; if (nfr !== 1) begin errors++; $display("FAIL ow_count got=%0d want=1", nfr); end
    checks++; if ({frame_value, frame_blank, frame_err} !== {16'h3216, 4'b0000, 1'b0}) begin errors++; $display("FAIL ow_frame got=%h want=%h", {frame_value, frame_blank, frame_err}, {16'h3216, 5'd0}); end
  endtask
  task automatic test_reset_mid();
    clr();
    scan(0, tbl[9]); scan(1, tbl[8]);
    rst = 1'b1;
    #2;
    checks++; if ({dig_strobe, dig_idx, dig_code, dig_blank, dig_err} !== 10'd0) begin errors++; $display("FAIL mid_rst_dig got=%h want=0", {dig_strobe, dig_idx, dig_code, dig_blank, dig_err}); end
    checks++; if ({frame_valid, frame_value, frame_blank, frame_err} !== 22'd0) begin errors++; $display("FAIL mid_rst_frame got=%h want=0", {frame_valid, frame_value, frame_blank, frame_err}); end
    @(posedge clk); #1;
    rst = 1'b0;
    clr();
    scan(2, tbl[12]); scan(3, tbl[14]);
    checks++; if (nfr !== 0) begin errors++; $display("FAIL mid_partial got=%0d want=0", nfr); end
    scan(0, tbl[11]); scan(1, tbl[10]);
    checks++; if (nfr !== 1) begin errors++; $display("FAIL mid_fresh got=%0d want=1", nfr); end
    checks++; if (frame_value !== 16'hECAB) begin errors++; $display("FAIL mid_value got=%h want=ecab", frame_value); end
  endtask
  task automatic test_extremes();
    int n1 = 0, at = -1, fat = -1;
    logic [3:0] v = '0, c = '0;
    for (int k = 0; k < 5; k++) begin
      an1 = 1'b0; seg1 = ~tbl[15];
      @(posedge clk); #1;
      if (d1_strobe) begin n1++; at = k; c = d1_code; end
      if (f1_valid) begin fat = k; v = f1_value; end
    end
    checks++; if (n1 !== 1) begin errors++; $display("FAIL ext_count got=%0d want=1", n1); end
    checks++; if (at !== 1) begin errors++; $display("FAIL ext_cycle got=%0d want=1", at); end
    checks++; if (fat !== 1) begin errors++; $display("FAIL ext_frame_cycle got=%0d want=1", fat); end
    checks++; if ({c, v} !== 8'hFF) begin errors++; $display("FAIL ext_value got=%h want=ff", {c, v}); end
  endtask
  initial begin
    test_reset();
    test_latency();
    test_full_frame();
    test_glitch();
    test_blank_invalid();
    test_overwrite();
    test_reset_mid();
    test_extremes();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
